bit_serializer: RTL and testbench

Parallel-to-serial stage that feeds the serial sequence-detector FSM. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per CLK on SOUT, with no gaps between back-to-back words. A one-word holding buffer lets the upstream present the next word while the current word shifts out.

---
 rtl/bit_serializer.sv | 117 +++++++++++
 tb/tb_bit_serializer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: WIDTH-bit words in over valid/ready, one bit per clock out.
// A one-word holding buffer lets back-to-back words stream out with no gap.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             SOUT,
    output logic             SOUT_VALID,
    output logic             SOUT_FIRST,
    output logic             SOUT_LAST,
    output logic             BUSY
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] hold_reg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    bit_cnt;
    logic             hold_full;
    logic             accept;
    logic             last_bit;
    logic             out_bit;

    assign accept   = DIN_VALID & ~hold_full;
    assign last_bit = (bit_cnt == LAST_CNT);

    // The output end of shift_reg is fixed; the word moves toward it.
    assign out_bit = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
    assign shifted = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_reg[WIDTH-1:1]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) state_next = SHIFT;
            end
            SHIFT: begin
                if (last_bit && !hold_full && !accept) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_reg <= '0;
            hold_reg  <= '0;
            bit_cnt   <= '0;
            hold_full <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= DIN;
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        shift_reg <= shifted;
                        bit_cnt   <= bit_cnt + CW'(1);
                        if (accept) begin
                            hold_reg  <= DIN;
                            hold_full <= 1'b1;
                        end
                    end else if (hold_full) begin
                        shift_reg <= hold_reg;
                        bit_cnt   <= '0;
                        hold_full <= 1'b0;
                    end else if (accept) begin
                        // Word arriving on the last-bit edge skips the buffer.
                        shift_reg <= DIN;
                        bit_cnt   <= '0;
                    end
                end
                default: begin
                    bit_cnt   <= '0;
                    hold_full <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        DIN_READY  = ~hold_full;
        SOUT_VALID = (state == SHIFT);
        SOUT       = SOUT_VALID ? out_bit : IDLE_BIT;
        SOUT_FIRST = SOUT_VALID & (bit_cnt == '0);
        SOUT_LAST  = SOUT_VALID & last_bit;
        BUSY       = SOUT_VALID | hold_full;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first/idle-0 and LSB-first/idle-1
// instances share one stimulus stream and are checked against a bit-count model.
module tb_bit_serializer;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] DIN = '0;
    logic         DIN_VALID = 1'b0;

    logic a_ready, a_sout, a_valid, a_first, a_last, a_busy;
    logic b_ready, b_sout, b_valid, b_first, b_last, b_busy;

    int   tests = 0;
    int   fails = 0;
    int   bits_left = 0;
    logic last_acc = 1'b0;
    exp_t qa[$];
    exp_t qb[$];

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(a_ready), .SOUT(a_sout), .SOUT_VALID(a_valid),
        .SOUT_FIRST(a_first), .SOUT_LAST(a_last), .BUSY(a_busy)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(b_ready), .SOUT(b_sout), .SOUT_VALID(b_valid),
        .SOUT_FIRST(b_first), .SOUT_LAST(b_last), .BUSY(b_busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, act, req, $time);
        end
    endtask

    // Reference model: bits not yet fully sent, plus the expected bit stream.
    // Holding buffer is full exactly when more than one word of bits is pending.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            bits_left = 0;
            last_acc  = 1'b0;
            qa.delete();
            qb.delete();
        end else begin
            last_acc = DIN_VALID && (bits_left <= W);
            if (bits_left > 0) bits_left--;
            if (last_acc) begin
                bits_left += W;
                for (int i = 0; i < W; i++) begin
                    qa.push_back('{DIN[W-1-i], i == 0, i == W-1});
                    qb.push_back('{DIN[i], i == 0, i == W-1});
                end
            end
        end
    end

    task automatic mon(input int k, input logic v, input logic s, input logic f,
                       input logic l, input logic r, input logic bz, input logic idle);
        string p;
        exp_t  e;
        int    sz;
        p = (k == 0) ? "A" : "B";
        chk({p, ".valid"}, v, bits_left > 0);
        chk({p, ".ready"}, r, bits_left <= W);
        chk({p, ".busy"}, bz, bits_left > 0);
        if (v) begin
            sz = (k == 0) ? qa.size() : qb.size();
            if (sz == 0) begin
                chk({p, ".underflow"}, 1, 0);
            end else begin
                e = (k == 0) ? qa.pop_front() : qb.pop_front();
                chk({p, ".bit"}, s, e.b);
                chk({p, ".first"}, f, e.f);
                chk({p, ".last"}, l, e.l);
            end
        end else begin
            chk({p, ".idle_bit"}, s, idle);
            chk({p, ".idle_first"}, f, 0);
            chk({p, ".idle_last"}, l, 0);
        end
    endtask

    always @(negedge CLK) begin
        mon(0, a_valid, a_sout, a_first, a_last, a_ready, a_busy, 1'b0);
        mon(1, b_valid, b_sout, b_first, b_last, b_ready, b_busy, 1'b1);
    end

    task automatic send(input logic [W-1:0] w);
        int n;
        n = 0;
        DIN = w;
        DIN_VALID = 1'b1;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (!last_acc && n < 100);
        if (!last_acc) chk("accept_timeout", 0, 1);
        DIN_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bits_left > 0 && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (bits_left > 0) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #12 RST = 1'b0;
        @(posedge CLK);
        #1;

        send(8'h98);
        wait_idle();
        repeat (2) @(posedge CLK);
        #1;

        send(8'h98);
        send(8'hA5);
        wait_idle();

        send(8'h11);
        send(8'h22);
        send(8'h33);
        wait_idle();

        repeat (20) @(posedge CLK);
        #1;

        send(8'h98);
        send(8'h55);
        repeat (2) @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("rst.a_valid", a_valid, 0);
        chk("rst.a_ready", a_ready, 1);
        chk("rst.a_busy", a_busy, 0);
        chk("rst.a_sout", a_sout, 0);
        chk("rst.b_valid", b_valid, 0);
        chk("rst.b_ready", b_ready, 1);
        chk("rst.b_busy", b_busy, 0);
        chk("rst.b_sout", b_sout, 1);
        @(negedge CLK);
        #2 RST = 1'b0;
        @(posedge CLK);
        #1;
        send(8'h01);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            send(W'($urandom));
            repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 12) : 0) begin
                @(posedge CLK);
                #1;
            end
        end
        wait_idle();
        repeat (3) @(posedge CLK);
        #1;
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
